// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch and data memory) sharing one single-port memory.
// Each access is IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE, with a starvation guard for IF.
module mem_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_SKIP = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
    localparam logic [SKIP_W-1:0] SKIP_LIMIT = SKIP_W'(MAX_SKIP);
    localparam logic [1:0] WAIT_LOAD = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                gnt_dm_q, gnt_dm_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                if_done_q, if_done_d;
    logic                dm_done_q, dm_done_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                busy_q, busy_d;
    logic                pick_if;

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        cnt_d      = cnt_q;
        gnt_dm_d   = gnt_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        busy_d     = busy_q;
        pick_if    = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    // DM normally wins a tie; IF wins once it has lost MAX_SKIP times in a row.
                    pick_if  = if_req && (!dm_req || (skip_q == SKIP_LIMIT));
                    gnt_dm_d = !pick_if;
                    we_d     = !pick_if && dm_we;
                    addr_d   = pick_if ? if_addr : dm_addr;
                    wdata_d  = pick_if ? '0 : dm_wdata;
                    if (pick_if) begin
                        skip_d = '0;
                    end else if (if_req && (skip_q != SKIP_LIMIT)) begin
                        skip_d = skip_q + SKIP_W'(1);
                    end
                    mem_en_d = 1'b1;
                    mem_we_d = !pick_if && dm_we;
                    busy_d   = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = WAIT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (!gnt_dm_q) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    if_done_d = !gnt_dm_q;
                    dm_done_d = gnt_dm_q;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            skip_q     <= '0;
            cnt_q      <= '0;
            gnt_dm_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            cnt_q      <= cnt_d;
            gnt_dm_q   <= gnt_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            busy_q     <= busy_d;
        end
    end

    // Latched address/data registers drive the memory bus directly, so they hold through WAIT.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W   32  data and address width
  MEM_LAT  1   memory read latency in cycles, legal range 1..4
  MAX_SKIP 2   consecutive IF losses allowed before IF is forced to win
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  Clk        in   1       system clock, rising edge
  Reset      in   1       synchronous, active-high reset
  if_req     in   1       instruction-fetch read request, level
  if_addr    in   DATA_W  fetch address
  if_done    out  1       one-cycle completion pulse for fetch
  if_rdata   out  DATA_W  fetched word, valid while if_done=1 and held after
  dm_req     in   1       data-memory request, level
  dm_we      in   1       1=store, 0=load
  dm_addr    in   DATA_W  data address
  dm_wdata   in   DATA_W  store data
  dm_done    out  1       one-cycle completion pulse for data access
  dm_rdata   out  DATA_W  load word, valid while dm_done=1 and held after
  mem_en     out  1       single-port memory access strobe
  mem_we     out  1       memory write enable
  mem_addr   out  DATA_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
  busy       out  1       1 in every state except IDLE
REQ-003 The block SHALL use one clock, Clk; Reset SHALL be synchronous and active-high.
REQ-004 All outputs SHALL be driven from registers.

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-006 IDLE: if any request is high at a rising edge, the block SHALL latch the winner's addr/we/wdata and go to ISSUE. Otherwise it SHALL stay in IDLE.
REQ-007 Arbitration in IDLE:
  - only one request high -> that requester wins
  - both high -> DM wins, unless skip_cnt==MAX_SKIP, in which case IF wins
REQ-008 skip_cnt SHALL increment (saturating) when IF is pending and DM wins, and SHALL clear to 0 on any IF grant.
REQ-009 ISSUE lasts 1 cycle with mem_en=1. mem_we=1 only for a DM store. IF accesses SHALL never assert mem_we.
REQ-010 WAIT SHALL last MEM_LAT cycles, counted by a down-counter. mem_en=0 and mem_we=0 throughout WAIT.
REQ-011 mem_addr and mem_wdata SHALL hold the latched values from ISSUE through the end of WAIT.
REQ-012 On the final WAIT cycle (MEM_LAT cycles after the ISSUE cycle), the block SHALL capture mem_rdata into the granted port's rdata register. Stores SHALL leave dm_rdata unchanged.
REQ-013 DONE lasts 1 cycle: the granted port's done=1, then the FSM returns to IDLE. Requests SHALL NOT be sampled in DONE.
REQ-014 Latency: request high in IDLE at edge t -> ISSUE at cycle t+1 -> done pulse at cycle t+MEM_LAT+2. Back-to-back service period SHALL be MEM_LAT+3 cycles.
REQ-015 A requester holding req high after its done pulse SHALL be treated as a new request in the next IDLE cycle.
REQ-016 A req that drops after grant SHALL NOT abort the access; done SHALL still pulse.
REQ-017 Exactly one of if_done and dm_done SHALL be high in DONE. Both SHALL be 0 in all other states.
REQ-018 rdata registers SHALL hold their value until overwritten by a later access to the same port.

Reset
REQ-019 Reset SHALL force IDLE in the same edge, including mid-access. The in-flight access SHALL produce no done pulse.
REQ-020 Reset values: all outputs 0, skip_cnt=0, latch registers 0, WAIT counter 0.

Verification
REQ-021 The bench SHALL cover these scenarios, with MEM_LAT=1 unless stated:
  - IF-only read: if_req=1, if_addr=0x40, mem_rdata=0x8C220004 -> mem_en at t+1, if_done at t+3, if_rdata=0x8C220004.
  - DM store: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> one cycle with mem_en=mem_we=1, mem_wdata=0xDEADBEEF, dm_done at t+3, dm_rdata unchanged.
  - Contention: if_req and dm_req held high continuously -> grant order DM, DM, IF, DM, DM, IF, with IF never skipped more than 2 times in a row.
  - MEM_LAT=3 load at dm_addr=0x200 -> mem_en at t+1, capture at t+4, dm_done at t+5.
  - Reset asserted during WAIT -> next cycle busy=0, no done pulse, all outputs 0; a new request after reset is served normally.
  - req dropped in the cycle after ISSUE -> done still pulses once, and no second access is issued.
